// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package fetch_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 16;
   localparam int DEPTH_DEF   = 4;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; clear wins over push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t      mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues pc_in to memory, queues returned {pc, instr} for decode,
// and drives the PC load port for execute redirects and for replaying dropped responses.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH   = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_in,
   output logic               jump_enable,
   output logic [PC_W-1:0]    jump_address,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_addr,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc
);

   logic                    resp_valid_q;
   logic [PC_W-1:0]         resp_pc_q;
   logic                    pop;
   logic                    can_enq;
   logic                    push;
   logic                    replay;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    empty;
   fetch_entry_t            push_entry;
   fetch_entry_t            head;

   assign imem_addr  = pc_in;
   assign id_valid   = (count != '0);
   assign pop        = ~empty & id_ready;
   assign can_enq    = ~full | pop;
   assign push       = resp_valid_q & can_enq & ~redirect_valid;
   assign replay     = resp_valid_q & ~can_enq & ~redirect_valid;
   assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

   assign id_pc    = id_valid ? head.pc    : '0;
   assign id_instr = id_valid ? head.instr : '0;

   // Redirect outranks replay; a replayed response is dropped and re-fetched by the PC.
   // NOTE: outputs get defaults before any branch so no path leaves them unassigned (no latch).
   always_comb begin
      jump_enable  = 1'b0;
      jump_address = '0;
      if (redirect_valid) begin
         jump_enable  = 1'b1;
         jump_address = redirect_addr;
      end else if (replay) begin
         jump_enable  = 1'b1;
         jump_address = resp_pc_q;
      end
   end

   // Whenever the PC is being loaded this cycle, the word issued now is wrong-path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_pc_q    <= '0;
      end else begin
         resp_valid_q <= ~jump_enable;
         resp_pc_q    <= pc_in;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (redirect_valid),
      .wdata (push_entry),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a PC counter and synchronous ROM around the DUT,
// with decode-side pops checked against the expected architectural PC stream.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pc_in;
   logic        jump_enable;
   logic [7:0]  jump_address;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_addr = 8'h00;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [15:0] id_instr;
   logic [7:0]  id_pc;

   always #5 clk = ~clk;

   fetch_stage #(
      .PC_W    (8),
      .INSTR_W (16),
      .DEPTH   (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .jump_enable    (jump_enable),
      .jump_address   (jump_address),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   // Environment: free-running program counter with load port, and a 1-cycle ROM.
   logic [15:0] rom [256];

   always @(posedge clk or posedge reset) begin
      if (reset)            pc_in <= 8'h00;
      else if (jump_enable) pc_in <= jump_address;
      else                  pc_in <= pc_in + 8'd1;
   end

   always @(posedge clk) imem_rdata <= rom[imem_addr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: decode must see consecutive PCs, restarting at each redirect target.
   logic [7:0] exp_pc = 8'h00;
   int         n_pops = 0;
   logic [7:0] pop_log [$];
   logic       s_valid, s_je;
   logic [7:0] s_ja, s_pc;
   logic       arm = 1'b0;
   logic [7:0] arm_when = 8'h00;
   logic [7:0] arm_target = 8'h00;
   logic       fired = 1'b0;

   task automatic run_cycle(input logic rdy, input logic rv, input logic [7:0] ra);
      logic       v;
      logic [7:0] a;
      @(negedge clk);
      v = rv;
      a = ra;
      fired = 1'b0;
      if (arm && pc_in == arm_when) begin
         v = 1'b1;
         a = arm_target;
         arm = 1'b0;
         fired = 1'b1;
      end
      id_ready       = rdy;
      redirect_valid = v;
      redirect_addr  = a;
      #1;
      s_valid = id_valid;
      s_je    = jump_enable;
      s_ja    = jump_address;
      s_pc    = id_pc;
      if (id_valid && id_ready) begin
         check("pop_pc", 32'(id_pc), 32'(exp_pc));
         check("pop_instr", 32'(id_instr), 32'(rom[exp_pc]));
         pop_log.push_back(id_pc);
         n_pops++;
         exp_pc = exp_pc + 8'd1;
      end
      if (v) begin
         check("redir_je", 32'(jump_enable), 32'(1));
         check("redir_ja", 32'(jump_address), 32'(a));
         exp_pc = a;
      end else if (!jump_enable) begin
         check("idle_ja", 32'(jump_address), 32'(0));
      end
   endtask

   task automatic reset_dut();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      arm            = 1'b0;
      @(negedge clk);
      #1;
      exp_pc = 8'h00;
      n_pops = 0;
      pop_log.delete();
   endtask

   // Called right after reset release: first word after exactly two edges, then streaming.
   task automatic check_restart();
      int first;
      first = 0;
      for (int i = 1; i <= 6; i++) begin
         run_cycle(1'b1, 1'b0, 8'h00);
         if (s_valid && first == 0) begin
            first = i;
            check("first_pc", 32'(s_pc), 32'(0));
         end
      end
      check("first_latency", 32'(first), 32'(2));
      for (int i = 0; i < 12; i++) begin
         run_cycle(1'b1, 1'b0, 8'h00);
         check("stream_valid", 32'(s_valid), 32'(1));
         check("stream_je", 32'(s_je), 32'(0));
      end
      check("stream_pops", 32'(n_pops), 32'(17));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         replays;
      int         guard;
      int         bad;
      logic [7:0] wrap_exp [4];
      wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);

      // Reset values, then first word and steady stream.
      reset_dut();
      @(negedge clk);
      #1;
      check("rst_valid", 32'(id_valid), 32'(0));
      check("rst_je", 32'(jump_enable), 32'(0));
      check("rst_ja", 32'(jump_address), 32'(0));
      check("rst_pc", 32'(id_pc), 32'(0));
      check("rst_instr", 32'(id_instr), 32'(0));
      reset = 1'b0;
      check_restart();

      // Backpressure from reset: fill with PCs 0..3, replay PC 4 every other cycle.
      reset_dut();
      id_ready = 1'b0;
      reset = 1'b0;
      replays = 0;
      for (int i = 1; i <= 12; i++) begin
         run_cycle(1'b0, 1'b0, 8'h00);
         if (i <= 4) check("bp_no_jump", 32'(s_je), 32'(0));
         if (i == 5) check("bp_first_replay", 32'(s_je), 32'(1));
         if (i >= 5 && s_je) begin
            replays++;
            check("bp_replay_ja", 32'(s_ja), 32'(4));
         end
      end
      check("bp_replays", 32'(replays), 32'(4));
      check("bp_head_valid", 32'(s_valid), 32'(1));
      check("bp_head_pc", 32'(s_pc), 32'(0));
      guard = 0;
      while (n_pops < 8 && guard < 40) begin
         run_cycle(1'b1, 1'b0, 8'h00);
         guard++;
      end
      check("bp_drained", 32'(n_pops >= 8), 32'(1));

      // Redirect to 0x40 while pc_in is 0x10.
      reset_dut();
      reset = 1'b0;
      arm = 1'b1;
      arm_when = 8'h10;
      arm_target = 8'h40;
      guard = 0;
      fired = 1'b0;
      while (!fired && guard < 40) begin
         run_cycle(1'b1, 1'b0, 8'h00);
         guard++;
      end
      check("rd_fired", 32'(fired), 32'(1));
      check("rd_ja", 32'(s_ja), 32'(8'h40));
      run_cycle(1'b1, 1'b0, 8'h00);
      check("rd_flush_t1", 32'(s_valid), 32'(0));
      run_cycle(1'b1, 1'b0, 8'h00);
      check("rd_flush_t2", 32'(s_valid), 32'(0));
      run_cycle(1'b1, 1'b0, 8'h00);
      check("rd_target_valid", 32'(s_valid), 32'(1));
      check("rd_target_pc", 32'(s_pc), 32'(8'h40));
      for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 8'h00);
      bad = 0;
      foreach (pop_log[k]) if (pop_log[k] == 8'h10 || pop_log[k] == 8'h11) bad++;
      check("rd_no_wrong_path", 32'(bad), 32'(0));

      // Redirect to 0x80 while full and replaying.
      reset_dut();
      id_ready = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 8'h00);
      run_cycle(1'b0, 1'b1, 8'h80);
      check("rr_je", 32'(s_je), 32'(1));
      check("rr_ja", 32'(s_ja), 32'(8'h80));
      run_cycle(1'b1, 1'b0, 8'h00);
      check("rr_empty", 32'(s_valid), 32'(0));
      run_cycle(1'b1, 1'b0, 8'h00);
      run_cycle(1'b1, 1'b0, 8'h00);
      check("rr_target_valid", 32'(s_valid), 32'(1));
      check("rr_target_pc", 32'(s_pc), 32'(8'h80));
      for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, 8'h00);

      // PC wrap-around through a redirect to 0xFE.
      run_cycle(1'b1, 1'b1, 8'hFE);
      pop_log.delete();
      guard = 0;
      while (pop_log.size() < 4 && guard < 12) begin
         run_cycle(1'b1, 1'b0, 8'h00);
         guard++;
      end
      check("wrap_count", 32'(pop_log.size() >= 4), 32'(1));
      for (int k = 0; k < 4 && k < pop_log.size(); k++)
         check("wrap_pc", 32'(pop_log[k]), 32'(wrap_exp[k]));

      // Asynchronous reset mid-stream with the queue partly occupied.
      for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b0, 8'h00);
      check("mid_busy", 32'(s_valid), 32'(1));
      #2;
      reset = 1'b1;
      #1;
      check("mid_valid", 32'(id_valid), 32'(0));
      check("mid_je", 32'(jump_enable), 32'(0));
      reset_dut();
      reset = 1'b0;
      check_restart();

      // Random traffic: random ROM contents, decode stalls and redirects.
      reset_dut();
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      reset = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, 8'($urandom));
      end
      check("rand_progress", 32'(n_pops > 500), 32'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter and upstream of decode. It forwards the current PC to a synchronous instruction memory, captures the returned word with its PC, and buffers {pc, instr} pairs in a small queue for decode. The program counter increments unconditionally, so this stage owns the counter's `jump_enable`/`jump_address` inputs. It uses them both for execute-stage redirects and for replaying fetches the queue could not accept.

## Interface
- `PC_W`, 8, PC / address width (matches program counter)
- `INSTR_W`, 16, instruction word width
- `DEPTH`, 4, fetch queue entries (power of two, ≥2)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `pc_in`  in  PC_W  current PC from program counter
- `jump_enable`  out  1  load request to program counter
- `jump_address`  out  PC_W  load value to program counter
- `imem_addr`  out  PC_W  instruction memory address, `= pc_in` combinationally
- `imem_rdata`  in  INSTR_W  memory data, valid one cycle after address
- `redirect_valid`  in  1  taken branch/jump from execute
- `redirect_addr`  in  PC_W  redirect target
- `id_valid`  out  1  queue head valid
- `id_ready`  in  1  decode accepts head
- `id_instr`  out  INSTR_W  head instruction
- `id_pc`  out  PC_W  head PC

## Operation
- **Issue.** Every cycle, `pc_in` is issued to memory. Registers `resp_valid_q`/`resp_pc_q` capture `{~kill, pc_in}` at the clock edge. `kill` equals `jump_enable` of the same cycle, because that cycle's `pc_in` is wrong-path.
- **Response.** In cycle t, if `resp_valid_q` is set, the pair `{resp_pc_q, imem_rdata}` is presented for enqueue.
- **Enqueue space.** Enqueue is allowed when `count < DEPTH` or a pop occurs in the same cycle.
- **Pop.** A pop occurs when `id_valid & id_ready`. `id_valid = (count != 0)`. `id_pc` and `id_instr` come from the head entry.
- **Replay.** If a valid response cannot be enqueued and no redirect is present: drive `jump_enable=1` and `jump_address=resp_pc_q`, and drop the response. The PC re-fetches it; replay repeats until space exists.
- **Redirect.** Redirect has priority over replay. On `redirect_valid`: drive `jump_enable=1` and `jump_address=redirect_addr`. Clear the queue at the edge; any pop in that cycle is still honoured by decode but the queue ends empty. Discard the response arriving that cycle and kill that cycle's issue.
- **Idle.** With no redirect and no replay, `jump_enable=0` and `jump_address=0`.
- **Counters and wrap.** PC wrap-around (0xFF→0x00) needs no special handling. Queue pointers wrap modulo `DEPTH`; `count` is `$clog2(DEPTH)+1` bits wide.
- **Simultaneous push/pop.**
  - When full: count stays `DEPTH`.
  - When empty: push only. There is no bypass, so a word is never visible in the cycle it arrives.

## Timing
- **Reset values.** While reset is active: `resp_valid_q=0`, `count=0`, pointers `0`, `id_valid=0`, `jump_enable=0`, `jump_address=0`. `id_pc` and `id_instr` are don't-care while `id_valid=0`; the implementation drives them to 0.
- **Reset mid-operation.** Clears everything immediately and asynchronously. In-flight responses are lost.
- **Latency.** From the PC value on `pc_in` to `id_valid` for that PC is 2 cycles (memory 1 cycle, queue register 1 cycle).
- **After reset release.** Edge 1 captures PC 0 in flight. PC 0 is visible at decode after edge 2.
- **Redirect.** `redirect_valid` in cycle t gives target at `pc_in` in t+1 and the target's `id_valid` in t+3. No wrong-path entry ever reaches `id_valid`.
- **Replay.** A dropped response in cycle t is re-issued in t+1 and re-arrives in t+2.
- **Steady state.** With `id_ready` held high, throughput is one instruction per cycle.

## Structure
- **Package `fetch_pkg`:**
  - `PC_W` and `INSTR_W` defaults.
  - `fetch_entry_t` packed struct {pc, instr}.
- **Sub-module `fetch_fifo`:** synchronous FIFO of `fetch_entry_t` with `push`, `pop`, synchronous `clear` (priority over push), `count`, `full`, `empty`. Async reset.
- **Top level** holds the response registers and the jump/replay/kill logic.

## Test plan
- **Reset and stream.** Release reset; memory returns `0xA000+addr`; `id_ready=1`. Required: first `id_valid` 2 cycles after reset release with `id_pc=0`, `id_instr=0xA000`. Then PCs 1, 2, 3 … on consecutive cycles; `jump_enable` never asserted.
- **Backpressure replay.** Hold `id_ready=0` from reset. Required:
  - The queue fills with PCs 0–3.
  - The next response (PC 4) causes `jump_enable=1`, `jump_address=4`, repeating while the queue is full.
  - Raising `id_ready` yields PCs 0, 1, 2, 3, 4, 5 in order, with no gap duplicates or loss.
- **Redirect.** While streaming, pulse `redirect_valid`, `redirect_addr=0x40` at the cycle `pc_in=0x10`. Required: queue flushed, `jump_address=0x40` that cycle. The next `id_pc` after any popped head is `0x40`, with `0x10`/`0x11` never appearing.
- **Redirect during replay.** Queue full and replay active, then `redirect_valid` with target `0x80`. Required: `jump_address=0x80`, queue empty next cycle, then stream from `0x80`.
- **Wrap-around.** Redirect to `0xFE`. Required: `id_pc` sequence `0xFE, 0xFF, 0x00, 0x01`.
- **Reset mid-operation.** Assert reset asynchronously mid-stream with the queue half full. Required: `id_valid=0` and `jump_enable=0` immediately, before the next clock edge. Restart from PC 0 per the first scenario.
